// File: rtl/step_dir_decoder_pkg.sv
// Shared definitions for the step/dir receiver: default widths, microstep
// scaling and FSM state encoding. The step-motor channel uses the same values
// so both ends agree on position units.
package step_dir_decoder_pkg;

  // Finest microstep exponent; position LSB is 1/2^MsMax of a full step
  localparam int unsigned MsMax           = 5;
  localparam int unsigned StepNumberWidth = 16;
  localparam int unsigned SpeedDataWidth  = 16;
  localparam int unsigned MicrostepWidth  = 3;
  localparam int unsigned PositionWidth   = 32;
  localparam int unsigned MinHigh         = 4;
  localparam int unsigned DirSetup        = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

  // Shift applied to 1 to get the per-edge position increment.
  // Exponents beyond the finest microstep fall back to the smallest increment.
  function automatic int unsigned ms_shift(int unsigned ms, int unsigned ms_max);
    return (ms > ms_max) ? 0 : (ms_max - ms);
  endfunction

endpackage

// File: rtl/step_dir_decoder_sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous pin with rise/fall strobes.
// Strobes stay quiet until the chain and the edge history hold real samples,
// so a pin that is already high when reset releases does not look like a rise.
module step_dir_decoder_sync_edge_detect #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic [Stages:0]   vld_q;
  logic              prev_q;

  // Synchroniser chain, edge history and fill tracker
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      vld_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      vld_q  <= {vld_q[Stages-1:0], 1'b1};
      prev_q <= sync_q[Stages-1];
    end
  end

  // Edge strobes, gated until the history register holds a synchronised sample
  always_comb begin
    level_o = sync_q[Stages-1];
    rise_o  = vld_q[Stages] & level_o & ~prev_q;
    fall_o  = vld_q[Stages] & ~level_o & prev_q;
  end

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir pin receiver: rebuilds signed microstep position, step count,
// pulse period and motion state from the drive/dir/ms pins, and flags runt
// pulses and late direction changes.
module step_dir_decoder
  import step_dir_decoder_pkg::*;
#(
  parameter int unsigned C_STEP_NUMBER_WIDTH = StepNumberWidth,
  parameter int unsigned C_SPEED_DATA_WIDTH  = SpeedDataWidth,
  parameter int unsigned C_MICROSTEP_WIDTH   = MicrostepWidth,
  parameter int unsigned C_MS_MAX            = MsMax,
  parameter int unsigned C_POSITION_WIDTH    = PositionWidth,
  parameter int unsigned C_MIN_HIGH          = MinHigh,
  parameter int unsigned C_DIR_SETUP         = DirSetup
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           i_drive,
  input  logic                           i_dir,
  input  logic [C_MICROSTEP_WIDTH-1:0]   i_ms,
  input  logic                           i_clr,
  output logic                           o_step_pls,
  output logic [C_POSITION_WIDTH-1:0]    o_position,
  output logic [C_STEP_NUMBER_WIDTH-1:0] o_step_cnt,
  output logic [C_SPEED_DATA_WIDTH-1:0]  o_period,
  output logic                           o_moving,
  output logic                           o_err_runt,
  output logic                           o_err_dir
);

  localparam int unsigned DirCntW = (C_DIR_SETUP < 2) ? 1 : $clog2(C_DIR_SETUP + 1);

  localparam logic [DirCntW-1:0]             DirSetupVal = DirCntW'(C_DIR_SETUP);
  localparam logic [DirCntW-1:0]             DirOne      = DirCntW'(1);
  localparam logic [C_SPEED_DATA_WIDTH-1:0]  SpdMax      = '1;
  localparam logic [C_SPEED_DATA_WIDTH-1:0]  SpdOne      = C_SPEED_DATA_WIDTH'(1);
  localparam logic [C_SPEED_DATA_WIDTH-1:0]  MinHighVal  = C_SPEED_DATA_WIDTH'(C_MIN_HIGH);
  localparam logic [C_STEP_NUMBER_WIDTH-1:0] CntMax      = '1;
  localparam logic [C_STEP_NUMBER_WIDTH-1:0] CntOne      = C_STEP_NUMBER_WIDTH'(1);

  logic drive_lvl, drive_rise, drive_fall;
  logic dir_lvl, dir_rise, dir_fall;

  step_dir_decoder_sync_edge_detect #(
    .Stages (2)
  ) u_sync_drive (
    .clk_i  (clk),
    .rst_ni (resetn),
    .d_i    (i_drive),
    .level_o(drive_lvl),
    .rise_o (drive_rise),
    .fall_o (drive_fall)
  );

  step_dir_decoder_sync_edge_detect #(
    .Stages (2)
  ) u_sync_dir (
    .clk_i  (clk),
    .rst_ni (resetn),
    .d_i    (i_dir),
    .level_o(dir_lvl),
    .rise_o (dir_rise),
    .fall_o (dir_fall)
  );

  state_e                         state_q, state_d;
  logic [C_SPEED_DATA_WIDTH-1:0]  per_cnt_q, per_cnt_d;
  logic [C_SPEED_DATA_WIDTH-1:0]  width_q, width_d;
  logic [DirCntW-1:0]             dir_cnt_q, dir_cnt_d;
  logic                           step_pls_q, step_pls_d;
  logic [C_POSITION_WIDTH-1:0]    pos_q, pos_d;
  logic [C_STEP_NUMBER_WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [C_SPEED_DATA_WIDTH-1:0]  period_q, period_d;
  logic                           moving_q, moving_d;
  logic                           err_runt_q, err_runt_d;
  logic                           err_dir_q, err_dir_d;

  logic                        accept;
  logic                        runt;
  logic                        dir_chg;
  logic [DirCntW-1:0]          dir_stable;
  logic [C_POSITION_WIDTH-1:0] pos_inc;

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      per_cnt_q  <= '0;
      width_q    <= '0;
      dir_cnt_q  <= '0;
      step_pls_q <= 1'b0;
      pos_q      <= '0;
      step_cnt_q <= '0;
      period_q   <= '0;
      moving_q   <= 1'b0;
      err_runt_q <= 1'b0;
      err_dir_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      width_q    <= width_d;
      dir_cnt_q  <= dir_cnt_d;
      step_pls_q <= step_pls_d;
      pos_q      <= pos_d;
      step_cnt_q <= step_cnt_d;
      period_q   <= period_d;
      moving_q   <= moving_d;
      err_runt_q <= err_runt_d;
      err_dir_q  <= err_dir_d;
    end
  end

  // Pulse FSM, counters and position accumulator next-state
  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    width_d    = width_q;
    period_d   = period_q;
    moving_d   = moving_q;
    accept     = 1'b0;
    runt       = 1'b0;

    // A dir change in the same cycle as the edge counts as zero stable cycles
    dir_chg    = dir_rise | dir_fall;
    dir_stable = dir_chg ? '0 : dir_cnt_q;
    if (dir_chg) begin
      dir_cnt_d = '0;
    end else if (dir_cnt_q >= DirSetupVal) begin
      dir_cnt_d = DirSetupVal;
    end else begin
      dir_cnt_d = dir_cnt_q + DirOne;
    end

    case (state_q)
      StIdle: begin
        if (drive_rise) begin
          accept    = 1'b1;
          state_d   = StHigh;
          per_cnt_d = SpdOne;
          width_d   = SpdOne;
        end
      end
      StHigh: begin
        if (per_cnt_q == SpdMax) begin
          state_d  = StIdle;
          moving_d = 1'b0;
          period_d = '0;
        end else begin
          per_cnt_d = per_cnt_q + SpdOne;
          if (drive_fall) begin
            state_d = StLow;
            runt    = (width_q < MinHighVal);
          end else if (drive_lvl && (width_q != SpdMax)) begin
            width_d = width_q + SpdOne;
          end
        end
      end
      StLow: begin
        if (drive_rise) begin
          accept    = 1'b1;
          state_d   = StHigh;
          period_d  = per_cnt_q;
          per_cnt_d = SpdOne;
          width_d   = SpdOne;
          moving_d  = 1'b1;
        end else if (per_cnt_q == SpdMax) begin
          state_d  = StIdle;
          moving_d = 1'b0;
          period_d = '0;
        end else begin
          per_cnt_d = per_cnt_q + SpdOne;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    pos_inc    = C_POSITION_WIDTH'(1) << ms_shift(int'(i_ms), C_MS_MAX);
    step_pls_d = accept;
    pos_d      = pos_q;
    step_cnt_d = step_cnt_q;
    err_runt_d = err_runt_q | runt;
    err_dir_d  = err_dir_q | (accept & (dir_stable < DirSetupVal));

    if (accept) begin
      pos_d = dir_lvl ? (pos_q + pos_inc) : (pos_q - pos_inc);
      if (step_cnt_q != CntMax) begin
        step_cnt_d = step_cnt_q + CntOne;
      end
    end

    // Clear dominates a coincident edge; the strobe still fires
    if (i_clr) begin
      pos_d      = '0;
      step_cnt_d = '0;
      err_runt_d = 1'b0;
      err_dir_d  = 1'b0;
    end
  end

  // Registered outputs
  always_comb begin
    o_step_pls = step_pls_q;
    o_position = pos_q;
    o_step_cnt = step_cnt_q;
    o_period   = period_q;
    o_moving   = moving_q;
    o_err_runt = err_runt_q;
    o_err_dir  = err_dir_q;
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Self-checking bench for step_dir_decoder. Pulses are described at pin level
// (high/low widths, dir lead time, microstep) and a pulse-level model predicts
// position, count, period, motion and error flags from those numbers.
module tb_step_dir_decoder;

  localparam int unsigned MsMax    = 5;
  localparam int unsigned MinHigh  = 4;
  localparam int unsigned DirSetup = 2;
  localparam int unsigned SpdMax   = 65535;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_drive;
  logic        i_dir;
  logic [2:0]  i_ms;
  logic        i_clr;

  logic        o_step_pls;
  logic [31:0] o_position;
  logic [15:0] o_step_cnt;
  logic [15:0] o_period;
  logic        o_moving;
  logic        o_err_runt;
  logic        o_err_dir;

  logic        w8_step_pls;
  logic [7:0]  w8_position;
  logic [15:0] w8_step_cnt;
  logic [15:0] w8_period;
  logic        w8_moving;
  logic        w8_err_runt;
  logic        w8_err_dir;

  step_dir_decoder u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_drive   (i_drive),
    .i_dir     (i_dir),
    .i_ms      (i_ms),
    .i_clr     (i_clr),
    .o_step_pls(o_step_pls),
    .o_position(o_position),
    .o_step_cnt(o_step_cnt),
    .o_period  (o_period),
    .o_moving  (o_moving),
    .o_err_runt(o_err_runt),
    .o_err_dir (o_err_dir)
  );

  // Narrow-position instance: makes the signed wrap boundary reachable
  step_dir_decoder #(
    .C_POSITION_WIDTH(8)
  ) u_dut8 (
    .clk       (clk),
    .resetn    (resetn),
    .i_drive   (i_drive),
    .i_dir     (i_dir),
    .i_ms      (i_ms),
    .i_clr     (i_clr),
    .o_step_pls(w8_step_pls),
    .o_position(w8_position),
    .o_step_cnt(w8_step_cnt),
    .o_period  (w8_period),
    .o_moving  (w8_moving),
    .o_err_runt(w8_err_runt),
    .o_err_dir (w8_err_dir)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned pls_seen = 0;

  // Reference model state
  logic [31:0] m_pos;
  int unsigned m_cnt, m_period, m_pls, m_last_rise;
  bit          m_moving, m_err_runt, m_err_dir, m_have_prev;

  always @(negedge clk) begin
    if (resetn && o_step_pls) pls_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] p;
    p = m_pos;
    check({tag, ".pos"},    o_position, m_pos);
    check({tag, ".pos8"},   32'(w8_position), 32'(p[7:0]));
    check({tag, ".cnt"},    32'(o_step_cnt), m_cnt);
    check({tag, ".period"}, 32'(o_period), m_period);
    check({tag, ".moving"}, 32'(o_moving), 32'(m_moving));
    check({tag, ".runt"},   32'(o_err_runt), 32'(m_err_runt));
    check({tag, ".dirr"},   32'(o_err_dir), 32'(m_err_dir));
    check({tag, ".pls"},    pls_seen, m_pls);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    m_pos      = '0;
    m_cnt      = 0;
    m_err_runt = 1'b0;
    m_err_dir  = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_period    = 0;
    m_moving    = 1'b0;
    m_have_prev = 1'b0;
    m_last_rise = 0;
  endtask

  task automatic do_clr(input string tag);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    model_clear();
    repeat (3) tick();
    @(negedge clk);
    check_state(tag);
  endtask

  // One pin-level pulse; dlead = cycles between a dir change and the rise
  task automatic pulse(input int unsigned ms, input bit dir, input int unsigned dlead,
                       input int unsigned high, input int unsigned low, input bit clr_edge);
    bit          changed;
    int unsigned gap, inc;
    changed = (dir != i_dir);
    if (changed) begin
      i_dir = dir;
      repeat (dlead) tick();
    end
    i_ms    = 3'(ms);
    i_drive = 1'b1;

    m_pls++;
    inc = (ms > MsMax) ? 1 : (1 << (MsMax - ms));
    gap = cyc - m_last_rise;
    if (m_have_prev && gap <= SpdMax) begin
      m_period = gap;
      m_moving = 1'b1;
    end else begin
      m_period = 0;
      m_moving = 1'b0;
    end
    m_have_prev = 1'b1;
    m_last_rise = cyc;
    if (clr_edge) begin
      model_clear();
    end else begin
      m_pos = dir ? (m_pos + inc) : (m_pos - inc);
      if (m_cnt < 65535) m_cnt++;
      if (changed && dlead <= DirSetup) m_err_dir = 1'b1;
    end

    if (clr_edge) begin
      // Clear is sampled on the same edge that registers the step strobe
      tick();
      tick();
      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
      repeat (high - 3) tick();
    end else begin
      repeat (high) tick();
    end
    i_drive = 1'b0;
    if (high < MinHigh) m_err_runt = 1'b1;
    repeat (low) tick();
    @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ms, dlead, high, low;
    bit          dir, ce;

    resetn  = 1'b0;
    i_drive = 1'b0;
    i_dir   = 1'b0;
    i_ms    = '0;
    i_clr   = 1'b0;
    m_pls   = 0;
    model_reset();
    repeat (3) tick();
    @(negedge clk);
    check_state("reset");
    resetn = 1'b1;
    repeat (5) tick();

    // Full-resolution forward run, 100-cycle period
    for (int i = 0; i < 10; i++) begin
      pulse(5, 1'b1, 10, 8, 92, 1'b0);
      check_state($sformatf("fwd%0d", i));
    end

    // Full steps backwards, then an out-of-range exponent
    do_clr("clr1");
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1'b0, 10, 8, 20, 1'b0);
      check_state($sformatf("rev%0d", i));
    end
    pulse(7, 1'b0, 10, 8, 20, 1'b0);
    check_state("ms7");

    // Runt pulse, then clear
    pulse(5, 1'b0, 10, 2, 10, 1'b0);
    check_state("runt");
    do_clr("clr_runt");

    // Dir changed one cycle before the rise
    pulse(5, 1'b1, 1, 8, 20, 1'b0);
    check_state("dirlate");
    do_clr("clr_dir");

    // Randomised pulse trains
    for (int i = 0; i < 30; i++) begin
      ms    = $urandom_range(0, 7);
      dir   = 1'($urandom_range(0, 1));
      dlead = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(6, 10);
      high  = $urandom_range(2, 12);
      low   = $urandom_range(4, 40);
      ce    = (high >= 4) && ($urandom_range(0, 7) == 0);
      pulse(ms, dir, dlead, high, low, ce);
      check_state($sformatf("rnd%0d", i));
      if ($urandom_range(0, 9) == 0) do_clr($sformatf("rclr%0d", i));
    end

    // Clear on the strobe cycle
    pulse(3, 1'b1, 10, 6, 20, 1'b0);
    pulse(3, 1'b1, 10, 6, 20, 1'b1);
    check_state("clr_edge");

    // Reset mid-pulse, released while drive is still high
    i_drive = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    model_reset();
    repeat (3) tick();
    resetn = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check_state("rst_hold");
    i_drive = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check_state("rst_low");
    pulse(5, 1'b1, 10, 8, 20, 1'b0);
    check_state("rst_first");

    // Signed wrap on the 8-bit instance: 0x60 + 0x20 -> 0x80
    do_clr("clr_wrap");
    for (int i = 0; i < 4; i++) begin
      pulse(0, 1'b1, 10, 8, 20, 1'b0);
      check_state($sformatf("wrap%0d", i));
    end

    // Period timeout
    repeat (60000) tick();
    @(negedge clk);
    check_state("pre_timeout");
    repeat (6000) tick();
    @(negedge clk);
    m_moving = 1'b0;
    m_period = 0;
    check_state("timeout");
    pulse(5, 1'b1, 10, 8, 40, 1'b0);
    check_state("post_to1");
    pulse(5, 1'b1, 10, 8, 40, 1'b0);
    check_state("post_to2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
